// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Groups the two handshake ports of the RV32I fetch stage.
//   - Instruction memory port (req/gnt/rvalid): at most one fetch in flight,
//     responses return in order at least one cycle after the grant.
//   - IF/ID port (valid/ready): one registered entry {pc, instr} for decode.
//   Signal names keep the direction suffixes as seen from the fetch stage.
//
//   Modports
//     master : the fetch stage (drives imem_req_o/imem_addr_o and id_* outputs)
//     slave  : the environment (instruction memory + decode)
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_o;     // fetch request
  logic [XLEN-1:0] imem_addr_o;    // word-aligned fetch address
  logic            imem_gnt_i;     // request accepted this cycle
  logic            imem_rvalid_i;  // response valid
  logic [XLEN-1:0] imem_rdata_i;   // fetched instruction word
  logic            id_valid_o;     // IF/ID entry valid
  logic [XLEN-1:0] id_pc_o;        // PC of the entry
  logic [XLEN-1:0] id_instr_o;     // instruction of the entry
  logic            id_ready_i;     // decode accepts the entry this cycle

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   RV32I instruction-fetch stage placed directly after the branch comparator.
//   Owns the PC, issues one word fetch at a time to instruction memory,
//   redirects on a taken branch (squashing wrong-path fetches) and hands
//   {pc, instr} to decode through a one-entry valid/ready register.
//
//   Ports
//     clk_i            : clock, all state on the rising edge
//     rst_i            : synchronous active-high reset
//     branch_taken_i   : single-cycle redirect pulse (highest priority)
//     branch_target_i  : redirect target, bits [1:0] ignored
//     fetch_bus        : fetch_stage_if.master
//                        imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/
//                        imem_rdata_i and id_valid_o/id_pc_o/id_instr_o/
//                        id_ready_i
//
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  fetch_stage_if.master   fetch_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          state_q,     state_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] fetch_pc_q,  fetch_pc_d;
  logic            drop_q,      drop_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_pc_q,    buf_pc_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic            req_q,       req_d;
  logic [XLEN-1:0] addr_q,      addr_d;

  logic            accept_s;
  logic            space_s;
  logic            load_s;
  logic [XLEN-1:0] pc_adv_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            unused_tgt_lsb_s;

  // Target low bits are forced to zero; keep them visibly consumed.
  assign unused_tgt_lsb_s = ^branch_target_i[1:0];

  // Next-state logic: fetch FSM, PC update, squash flag and IF/ID entry.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    buf_valid_d   = buf_valid_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    load_s        = 1'b0;
    pc_adv_s      = pc_q;
    redirect_pc_s = {branch_target_i[XLEN-1:2], 2'b00};
    accept_s      = buf_valid_q & fetch_bus.id_ready_i;
    // The entry is free next cycle if it is empty or being accepted now.
    space_s       = ~buf_valid_q | accept_s;

    case (state_q)
      ST_IDLE: begin
        if (space_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (fetch_bus.imem_gnt_i) begin
          state_d    = ST_WAIT;
          fetch_pc_d = pc_q;
          pc_adv_s   = pc_q + PC_STEP;
          // A redirect in the grant cycle squashes the fetch just issued.
          if (branch_taken_i) begin
            drop_d = 1'b1;
          end else begin
            drop_d = drop_q;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (fetch_bus.imem_rvalid_i) begin
          if (!drop_q && !branch_taken_i) begin
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (branch_taken_i) begin
            drop_d = 1'b1;
          end else begin
            drop_d = drop_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect wins over sequential advance, including in the grant cycle.
    if (branch_taken_i) begin
      pc_d = redirect_pc_s;
    end else begin
      pc_d = pc_adv_s;
    end

    // IF/ID entry: redirect invalidates, a response refills, accept empties.
    if (branch_taken_i) begin
      buf_valid_d = 1'b0;
    end else if (load_s) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = fetch_pc_q;
      buf_instr_d = fetch_bus.imem_rdata_i;
    end else if (accept_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end

    // Memory outputs are precomputed so they leave the block from flops.
    req_d = (state_d == ST_REQ);
    if (state_d == ST_REQ) begin
      addr_d = pc_d;
    end else begin
      addr_d = {XLEN{1'b0}};
    end
  end

  // State register for the FSM, PC, squash flag, IF/ID entry and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= {XLEN{1'b0}};
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= {XLEN{1'b0}};
      buf_instr_q <= {XLEN{1'b0}};
      req_q       <= 1'b0;
      addr_q      <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
    end
  end

  assign fetch_bus.imem_req_o  = req_q;
  assign fetch_bus.imem_addr_o = addr_q;
  assign fetch_bus.id_valid_o  = buf_valid_q;
  assign fetch_bus.id_pc_o     = buf_pc_q;
  assign fetch_bus.id_instr_o  = buf_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam int unsigned XLEN    = 32;
  localparam logic [31:0] RST_PC1 = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, branch_taken_i;
  logic [31:0] branch_target_i;
  logic        rst2_i, br2_i;
  logic [31:0] tgt2_i;

  fetch_stage_if #(.XLEN(XLEN)) fbus  ();
  fetch_stage_if #(.XLEN(XLEN)) fbus2 ();

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC1)) dut (
    .clk_i(clk), .rst_i(rst_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .fetch_bus(fbus.master));

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC2)) dut2 (
    .clk_i(clk), .rst_i(rst2_i), .branch_taken_i(br2_i),
    .branch_target_i(tgt2_i), .fetch_bus(fbus2.master));

  int tests_run, tests_failed;
  int cyc;
  // memory responder state
  int gnt_pct, lat_min, lat_max;
  bit pend;
  logic [31:0] pend_addr;
  int pend_cnt;
  // reference model: the on-path instruction stream seen by decode
  logic [31:0] exp_pc;
  int n_acc;
  logic [31:0] last_acc_pc;
  bit hold_chk;
  logic [31:0] hold_pc, hold_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  // One clock of dut: memory model drives gnt/rvalid, model tracks decode.
  task automatic cycle();
    logic gnt_s, rv_s, req_s, v_s, rdy_s, br_s, rst_s;
    logic [31:0] addr_s, pc_s, instr_s, tgt_s;
    gnt_s = 1'b0;
    rv_s  = 1'b0;
    if (pend && pend_cnt == 0) rv_s = 1'b1;
    if (fbus.imem_req_o === 1'b1 && !pend && ($urandom_range(0, 99) < gnt_pct)) gnt_s = 1'b1;
    fbus.imem_gnt_i    = gnt_s;
    fbus.imem_rvalid_i = rv_s;
    fbus.imem_rdata_i  = rv_s ? instr_of(pend_addr) : 32'hDEAD_BEEF;
    req_s = fbus.imem_req_o; addr_s = fbus.imem_addr_o;
    v_s = fbus.id_valid_o; pc_s = fbus.id_pc_o; instr_s = fbus.id_instr_o;
    rdy_s = fbus.id_ready_i; br_s = branch_taken_i; tgt_s = branch_target_i; rst_s = rst_i;
    @(posedge clk);
    cyc++;
    if (rst_s) pend = 1'b0;
    else if (gnt_s) begin
      pend = 1'b1; pend_addr = addr_s;
      pend_cnt = int'($urandom_range(lat_min, lat_max)) - 1;
    end else if (rv_s) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (!rst_s && req_s === 1'b1) begin
      tests_run++;
      if (addr_s[1:0] !== 2'b00) begin
        tests_failed++; $display("FAIL addr_align: got %h required low bits 00", addr_s);
      end
    end
    if (rst_s) begin
      exp_pc = RST_PC1; hold_chk = 1'b0;
    end else if (br_s) begin
      exp_pc = {tgt_s[31:2], 2'b00}; hold_chk = 1'b0;
    end else if (v_s === 1'b1 && rdy_s) begin
      tests_run++;
      if (pc_s !== exp_pc || instr_s !== instr_of(exp_pc)) begin
        tests_failed++;
        $display("FAIL accept: got pc=%h instr=%h required pc=%h instr=%h", pc_s, instr_s, exp_pc, instr_of(exp_pc));
      end
      exp_pc = exp_pc + 32'd4; n_acc++; last_acc_pc = pc_s; hold_chk = 1'b0;
    end else if (v_s === 1'b1) begin
      hold_chk = 1'b1; hold_pc = pc_s; hold_instr = instr_s;
    end else hold_chk = 1'b0;
    #1;
    if (hold_chk) begin
      tests_run++;
      if (fbus.id_valid_o !== 1'b1 || fbus.id_pc_o !== hold_pc || fbus.id_instr_o !== hold_instr) begin
        tests_failed++;
        $display("FAIL hold: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h",
                 fbus.id_valid_o, fbus.id_pc_o, fbus.id_instr_o, hold_pc, hold_instr);
      end
    end
  endtask

  task automatic cycle2();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; branch_taken_i = 1'b0; branch_target_i = 32'h0;
    fbus.id_ready_i = 1'b1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    cycle(); cycle();
    rst_i = 1'b0;
    tests_run++;
    if (fbus.imem_req_o !== 1'b0 || fbus.imem_addr_o !== 32'h0 || fbus.id_valid_o !== 1'b0 ||
        fbus.id_pc_o !== 32'h0 || fbus.id_instr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b pc=%h instr=%h required all 0",
               fbus.imem_req_o, fbus.imem_addr_o, fbus.id_valid_o, fbus.id_pc_o, fbus.id_instr_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] addr_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] ins_q[$];
    int cyc_q[$];
    for (int i = 0; i < 12; i++) begin
      if (fbus.imem_req_o === 1'b1) addr_q.push_back(fbus.imem_addr_o);
      cycle();
      if (fbus.id_valid_o === 1'b1) begin
        pc_q.push_back(fbus.id_pc_o); ins_q.push_back(fbus.id_instr_o); cyc_q.push_back(cyc);
      end
    end
    tests_run++;
    if (addr_q.size() < 3 || pc_q.size() < 3) begin
      tests_failed++;
      $display("FAIL seq_count: got %0d reqs %0d entries required >=3 each", addr_q.size(), pc_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (addr_q[k] !== 32'(4 * k) || pc_q[k] !== 32'(4 * k) || ins_q[k] !== instr_of(32'(4 * k))) begin
          tests_failed++;
          $display("FAIL seq_%0d: got addr=%h pc=%h instr=%h required %h", k, addr_q[k], pc_q[k], ins_q[k], 32'(4 * k));
        end
        if (k > 0) begin
          tests_run++;
          if (cyc_q[k] - cyc_q[k-1] != 3) begin
            tests_failed++;
            $display("FAIL seq_spacing_%0d: got %0d cycles required 3", k, cyc_q[k] - cyc_q[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    int guard;
    fbus.id_ready_i = 1'b0;
    guard = 0;
    while (fbus.id_valid_o !== 1'b1 && guard < 30) begin cycle(); guard++; end
    tests_run++;
    if (fbus.id_valid_o !== 1'b1) begin
      tests_failed++; $display("FAIL bp_fill: got valid=%b required 1 within 30 cycles", fbus.id_valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      tests_run++;
      if (fbus.imem_req_o !== 1'b0) begin
        tests_failed++; $display("FAIL bp_no_req: got req=%b required 0", fbus.imem_req_o);
      end
    end
    fbus.id_ready_i = 1'b1;
    n0 = n_acc; guard = 0;
    while (n_acc < n0 + 2 && guard < 30) begin cycle(); guard++; end
    tests_run++;
    if (n_acc < n0 + 2) begin
      tests_failed++; $display("FAIL bp_resume: got %0d accepts required 2", n_acc - n0);
    end
  endtask

  // Pulse a redirect now, then check the next fetch address and next accepted PC.
  task automatic redirect_and_check(input logic [31:0] tgt, input string nm, input bit chk_empty);
    int n0;
    int guard;
    logic [31:0] exp_t;
    exp_t = {tgt[31:2], 2'b00};
    branch_taken_i = 1'b1; branch_target_i = tgt;
    cycle();
    branch_taken_i = 1'b0;
    if (chk_empty) begin
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (fbus.id_valid_o !== 1'b0) begin
          tests_failed++; $display("FAIL %s_squash: got valid=%b required 0", nm, fbus.id_valid_o);
        end
        if (i == 0) cycle();
      end
    end
    guard = 0;
    while (fbus.imem_req_o !== 1'b1 && guard < 30) begin cycle(); guard++; end
    tests_run++;
    if (fbus.imem_req_o !== 1'b1 || fbus.imem_addr_o !== exp_t) begin
      tests_failed++; $display("FAIL %s_addr: got req=%b addr=%h required %h", nm, fbus.imem_req_o, fbus.imem_addr_o, exp_t);
    end
    fbus.id_ready_i = 1'b1;
    n0 = n_acc; guard = 0;
    while (n_acc == n0 && guard < 30) begin cycle(); guard++; end
    tests_run++;
    if (n_acc == n0 || last_acc_pc !== exp_t) begin
      tests_failed++; $display("FAIL %s_pc: got pc=%h required %h", nm, last_acc_pc, exp_t);
    end
  endtask

  task automatic test_redirect_wait();
    int guard;
    fbus.id_ready_i = 1'b1; gnt_pct = 100; lat_min = 3; lat_max = 3;
    guard = 0;
    while (!(pend && pend_cnt > 0) && guard < 30) begin cycle(); guard++; end
    tests_run++;
    if (!(pend && pend_cnt > 0)) begin
      tests_failed++; $display("FAIL rw_reach: got pend=%b required WAIT", pend);
    end
    redirect_and_check(32'h0000_0103, "rw", 1'b0);
  endtask

  task automatic test_redirect_gnt_rvalid();
    int guard;
    fbus.id_ready_i = 1'b1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    guard = 0;
    while (!(fbus.imem_req_o === 1'b1 && !pend) && guard < 30) begin cycle(); guard++; end
    redirect_and_check(32'h0000_0200, "rg", 1'b1);
    guard = 0;
    while (!(pend && pend_cnt == 0) && guard < 30) begin cycle(); guard++; end
    tests_run++;
    if (!(pend && pend_cnt == 0)) begin
      tests_failed++; $display("FAIL rv_reach: got pend=%b required rvalid cycle", pend);
    end
    redirect_and_check(32'h0000_0302, "rv", 1'b1);
  endtask

  task automatic test_redirect_stalled();
    int guard;
    fbus.id_ready_i = 1'b0; gnt_pct = 100; lat_min = 1; lat_max = 1;
    guard = 0;
    while (fbus.id_valid_o !== 1'b1 && guard < 30) begin cycle(); guard++; end
    cycle();
    redirect_and_check(32'h0000_0400, "rs", 1'b1);
  endtask

  task automatic test_random();
    int n0;
    n0 = n_acc; gnt_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      fbus.id_ready_i = ($urandom_range(0, 99) < 70);
      branch_taken_i  = ($urandom_range(0, 99) < 3);
      branch_target_i = $urandom();
      rst_i           = ($urandom_range(0, 999) < 2);
      cycle();
    end
    branch_taken_i = 1'b0; rst_i = 1'b0;
    tests_run++;
    if (n_acc - n0 < 100) begin
      tests_failed++; $display("FAIL rand_progress: got %0d accepts required >=100", n_acc - n0);
    end
  endtask

  task automatic test_wrap_and_reset();
    rst_i = 1'b1;
    fbus2.imem_gnt_i = 1'b0; fbus2.imem_rvalid_i = 1'b0; fbus2.imem_rdata_i = 32'h0;
    fbus2.id_ready_i = 1'b1; br2_i = 1'b0; tgt2_i = 32'h0;
    rst2_i = 1'b1; cycle2(); rst2_i = 1'b0;
    cycle2();
    tests_run++;
    if (fbus2.imem_req_o !== 1'b1 || fbus2.imem_addr_o !== RST_PC2) begin
      tests_failed++; $display("FAIL wrap_first: got req=%b addr=%h required 1 %h", fbus2.imem_req_o, fbus2.imem_addr_o, RST_PC2);
    end
    fbus2.imem_gnt_i = 1'b1; cycle2(); fbus2.imem_gnt_i = 1'b0;
    fbus2.imem_rvalid_i = 1'b1; fbus2.imem_rdata_i = 32'h1111_0013; cycle2(); fbus2.imem_rvalid_i = 1'b0;
    tests_run++;
    if (fbus2.id_valid_o !== 1'b1 || fbus2.id_pc_o !== RST_PC2 || fbus2.id_instr_o !== 32'h1111_0013) begin
      tests_failed++; $display("FAIL wrap_entry: got v=%b pc=%h instr=%h required 1 %h 11110013",
                               fbus2.id_valid_o, fbus2.id_pc_o, fbus2.id_instr_o, RST_PC2);
    end
    cycle2();
    tests_run++;
    if (fbus2.imem_req_o !== 1'b1 || fbus2.imem_addr_o !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_second: got req=%b addr=%h required 1 00000000", fbus2.imem_req_o, fbus2.imem_addr_o);
    end
    fbus2.imem_gnt_i = 1'b1; cycle2(); fbus2.imem_gnt_i = 1'b0;
    rst2_i = 1'b1; cycle2(); rst2_i = 1'b0;
    fbus2.imem_rvalid_i = 1'b1; fbus2.imem_rdata_i = 32'h2222_0013; cycle2(); fbus2.imem_rvalid_i = 1'b0;
    tests_run++;
    if (fbus2.id_valid_o !== 1'b0 || fbus2.imem_req_o !== 1'b1 || fbus2.imem_addr_o !== RST_PC2) begin
      tests_failed++; $display("FAIL late_rvalid: got v=%b req=%b addr=%h required 0 1 %h",
                               fbus2.id_valid_o, fbus2.imem_req_o, fbus2.imem_addr_o, RST_PC2);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; cyc = 0; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    exp_pc = RST_PC1; n_acc = 0; last_acc_pc = 32'h0; hold_chk = 1'b0;
    hold_pc = 32'h0; hold_instr = 32'h0;
    fbus.imem_gnt_i = 1'b0; fbus.imem_rvalid_i = 1'b0; fbus.imem_rdata_i = 32'h0; fbus.id_ready_i = 1'b1;
    rst2_i = 1'b1; br2_i = 1'b0; tgt2_i = 32'h0;
    fbus2.imem_gnt_i = 1'b0; fbus2.imem_rvalid_i = 1'b0; fbus2.imem_rdata_i = 32'h0; fbus2.id_ready_i = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt_rvalid();
    test_redirect_stalled();
    test_random();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
